dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory, with per-port lock ownership.
// Optional: define DMEM_ARB_RR_EN for round-robin arbitration (default: fixed priority to port 0).
module dmem_arbiter #(
   parameter int ADDR_W   = 10,
   parameter int LOCK_MAX = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req0,
   input  logic              i_req1,
   input  logic              i_we0,
   input  logic              i_we1,
   input  logic [ADDR_W-1:0] i_addr0,
   input  logic [ADDR_W-1:0] i_addr1,
   input  logic [31:0]       i_wdata0,
   input  logic [31:0]       i_wdata1,
   input  logic              i_lock0,
   input  logic              i_lock1,
   output logic              o_gnt0,
   output logic              o_gnt1,
   output logic              o_rvalid0,
   output logic              o_rvalid1,
   output logic [31:0]       o_rdata0,
   output logic [31:0]       o_rdata1,
   output logic              o_mem_wen,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [31:0]       o_mem_wdata,
   input  logic [31:0]       i_mem_rdata
);

   typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

   localparam logic [7:0] LOCK_LIM = 8'(LOCK_MAX);

   state_t      r_state, w_state_next;
   logic [7:0]  r_cnt, w_cnt_next, w_cnt_inc;
   logic        r_ptr, w_ptr_next;
   logic        w_gnt0, w_gnt1, w_forced;
   logic        w_act0, w_act1;
   logic        r_rvalid0, r_rvalid1;
   logic [31:0] r_rdata0, r_rdata1;

   assign w_cnt_inc = r_cnt + 8'd1;

   always_comb begin
      w_gnt0       = 1'b0;
      w_gnt1       = 1'b0;
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_forced     = 1'b0;
      case (r_state)
         IDLE: begin
            // r_ptr set means port 1 wins a contended cycle
            w_gnt0 = i_req0 & (~i_req1 | ~r_ptr);
            w_gnt1 = i_req1 & ~w_gnt0;
            if (w_gnt0 && i_lock0) begin
               w_state_next = OWN0;
               w_cnt_next   = 8'd1;
            end else if (w_gnt1 && i_lock1) begin
               w_state_next = OWN1;
               w_cnt_next   = 8'd1;
            end
         end
         OWN0: begin
            w_gnt0     = i_req0;
            w_cnt_next = w_cnt_inc;
            if (!i_lock0) begin
               w_state_next = IDLE;
               w_cnt_next   = 8'd0;
            end else if (w_cnt_inc == LOCK_LIM) begin
               w_state_next = IDLE;
               w_cnt_next   = 8'd0;
               w_forced     = 1'b1;
            end
         end
         OWN1: begin
            w_gnt1     = i_req1;
            w_cnt_next = w_cnt_inc;
            if (!i_lock1) begin
               w_state_next = IDLE;
               w_cnt_next   = 8'd0;
            end else if (w_cnt_inc == LOCK_LIM) begin
               w_state_next = IDLE;
               w_cnt_next   = 8'd0;
               w_forced     = 1'b1;
            end
         end
         default: begin
            w_state_next = IDLE;
            w_cnt_next   = 8'd0;
         end
      endcase
   end

   // A forced lock release hands the next contended arbitration to the other port.
   always_comb begin
`ifdef DMEM_ARB_RR_EN
      w_ptr_next = r_ptr;
      if (w_forced)
         w_ptr_next = (r_state == OWN0);
      else if (w_gnt0)
         w_ptr_next = 1'b1;
      else if (w_gnt1)
         w_ptr_next = 1'b0;
`else
      w_ptr_next = w_forced & (r_state == OWN0);
`endif
   end

   assign w_act0      = w_gnt0 & rst_n;
   assign w_act1      = w_gnt1 & rst_n;
   assign o_gnt0      = w_act0;
   assign o_gnt1      = w_act1;
   assign o_mem_wen   = (w_act0 & i_we0) | (w_act1 & i_we1);
   assign o_mem_addr  = w_act0 ? i_addr0  : (w_act1 ? i_addr1  : '0);
   assign o_mem_wdata = w_act0 ? i_wdata0 : (w_act1 ? i_wdata1 : 32'd0);
   assign o_rvalid0   = r_rvalid0;
   assign o_rvalid1   = r_rvalid1;
   assign o_rdata0    = r_rdata0;
   assign o_rdata1    = r_rdata1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_cnt     <= 8'd0;
         r_ptr     <= 1'b0;
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
         r_rdata0  <= 32'd0;
         r_rdata1  <= 32'd0;
      end else begin
         r_state   <= w_state_next;
         r_cnt     <= w_cnt_next;
         r_ptr     <= w_ptr_next;
         r_rvalid0 <= w_gnt0 & ~i_we0;
         r_rvalid1 <= w_gnt1 & ~i_we1;
         if (w_gnt0 && !i_we0)
            r_rdata0 <= i_mem_rdata;
         if (w_gnt1 && !i_we1)
            r_rdata1 <= i_mem_rdata;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic against a behavioural model.
// Honours DMEM_ARB_RR_EN the same way the design does.
`timescale 1ns/1ps
module tb_dmem_arbiter;
   localparam int ADDR_W   = 10;
   localparam int LOCK_MAX = 8;
   localparam int DEPTH    = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic              lock0 = 1'b0, lock1 = 1'b0;
   logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
   logic [31:0]       wdata0 = '0, wdata1 = '0;
   logic              gnt0, gnt1, rvalid0, rvalid1, mem_wen;
   logic [31:0]       rdata0, rdata1, mem_wdata, mem_rdata;
   logic [ADDR_W-1:0] mem_addr;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(ADDR_W), .LOCK_MAX(LOCK_MAX)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
      .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
      .i_lock0(lock0), .i_lock1(lock1),
      .o_gnt0(gnt0), .o_gnt1(gnt1), .o_rvalid0(rvalid0), .o_rvalid1(rvalid1),
      .o_rdata0(rdata0), .o_rdata1(rdata1),
      .o_mem_wen(mem_wen), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
      .i_mem_rdata(mem_rdata)
   );

   function automatic logic [31:0] seed(input int a);
      return 32'hC0DE_0000 + 32'(a) * 32'h0001_0003;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Memory: write captured mid-cycle, committed at the closing edge.
   logic [31:0] mem [DEPTH];
   assign mem_rdata = mem[mem_addr];
   initial begin
      logic              pw;
      logic [ADDR_W-1:0] pa;
      logic [31:0]       pd;
      for (int i = 0; i < DEPTH; i++) mem[i] = seed(i);
      forever begin
         @(negedge clk);
         pw = mem_wen; pa = mem_addr; pd = mem_wdata;
         @(posedge clk);
         if (pw) mem[pa] = pd;
      end
   end

   // Reference model: owner (-1 = nobody), cycles held, preferred port on contention.
   logic [31:0] ref_mem [DEPTH];
   initial begin
      int                own, held, pref, win, loser;
      bit                forced;
      logic              e_rv0, e_rv1, e_wen;
      logic [31:0]       e_rd0, e_rd1, e_wd;
      logic [ADDR_W-1:0] e_ad;
      own = -1; held = 0; pref = 0;
      e_rv0 = 1'b0; e_rv1 = 1'b0; e_rd0 = '0; e_rd1 = '0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed(i);
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk1("rst_gnt0", gnt0, 1'b0);
            chk1("rst_gnt1", gnt1, 1'b0);
            chk1("rst_wen", mem_wen, 1'b0);
            chk("rst_addr", 32'(mem_addr), 32'd0);
            chk1("rst_rvalid0", rvalid0, 1'b0);
            chk1("rst_rvalid1", rvalid1, 1'b0);
            chk("rst_rdata0", rdata0, 32'd0);
            chk("rst_rdata1", rdata1, 32'd0);
            own = -1; held = 0; pref = 0;
            e_rv0 = 1'b0; e_rv1 = 1'b0; e_rd0 = '0; e_rd1 = '0;
            continue;
         end
         if (own < 0) begin
            if (req0 && req1) win = pref;
            else if (req0)    win = 0;
            else if (req1)    win = 1;
            else              win = -1;
         end else begin
            win = ((own == 0) ? req0 : req1) ? own : -1;
         end
         e_wen = 1'b0; e_ad = '0; e_wd = '0;
         if (win == 0) begin e_wen = we0; e_ad = addr0; e_wd = wdata0; end
         if (win == 1) begin e_wen = we1; e_ad = addr1; e_wd = wdata1; end
         chk1("gnt0", gnt0, win == 0);
         chk1("gnt1", gnt1, win == 1);
         chk1("mem_wen", mem_wen, e_wen);
         chk("mem_addr", 32'(mem_addr), 32'(e_ad));
         chk("mem_wdata", mem_wdata, e_wd);
         chk1("rvalid0", rvalid0, e_rv0);
         chk1("rvalid1", rvalid1, e_rv1);
         chk("rdata0", rdata0, e_rd0);
         chk("rdata1", rdata1, e_rd1);
         e_rv0 = 1'b0; e_rv1 = 1'b0;
         if (win >= 0) begin
            if (e_wen) ref_mem[e_ad] = e_wd;
            else if (win == 0) begin e_rv0 = 1'b1; e_rd0 = ref_mem[e_ad]; end
            else begin e_rv1 = 1'b1; e_rd1 = ref_mem[e_ad]; end
         end
         forced = 1'b0;
         loser  = own;
         if (own < 0) begin
            if (win >= 0 && ((win == 0) ? lock0 : lock1)) begin own = win; held = 1; end
         end else begin
            held++;
            if (!((own == 0) ? lock0 : lock1)) own = -1;
            else if (held == LOCK_MAX) begin forced = 1'b1; own = -1; end
         end
`ifdef DMEM_ARB_RR_EN
         if (forced) pref = 1 - loser;
         else if (win >= 0) pref = 1 - win;
`else
         pref = forced ? 1 - loser : 0;
`endif
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
   endtask

   task automatic do_reset();
      next_cycle();
      rst_n = 1'b0;
      clear_inputs();
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
   endtask

   initial begin
      int  exp_port [4];
      bit  g0_last, g1_last;

      // Write then read back at the same word.
      do_reset();
      next_cycle(); req0 = 1'b1; we0 = 1'b1; addr0 = 10'h004; wdata0 = 32'hDEADBEEF;
      @(negedge clk); chk1("d_wr_gnt0", gnt0, 1'b1);
      next_cycle(); we0 = 1'b0;
      @(negedge clk); chk1("d_rd_gnt0", gnt0, 1'b1);
      next_cycle(); req0 = 1'b0;
      @(negedge clk); chk1("d_rd_rvalid0", rvalid0, 1'b1); chk("d_rd_rdata0", rdata0, 32'hDEADBEEF);
      next_cycle();
      @(negedge clk); chk1("d_rd_rvalid0_off", rvalid0, 1'b0); chk("d_rd_hold", rdata0, 32'hDEADBEEF);
      $display("scenario write/read-back done");

      // Contended reads, no lock.
`ifdef DMEM_ARB_RR_EN
      exp_port[0] = 0; exp_port[1] = 1; exp_port[2] = 0; exp_port[3] = 1;
`else
      exp_port[0] = 0; exp_port[1] = 0; exp_port[2] = 0; exp_port[3] = 0;
`endif
      do_reset();
      next_cycle(); req0 = 1'b1; addr0 = 10'h001; req1 = 1'b1; addr1 = 10'h002;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk1("d_cont_gnt0", gnt0, exp_port[k] == 0);
         chk1("d_cont_gnt1", gnt1, exp_port[k] == 1);
         next_cycle();
      end
      clear_inputs();
      $display("scenario contended reads done");

      // Port 1 lock held past LOCK_MAX while port 0 waits.
      do_reset();
      next_cycle(); req1 = 1'b1; lock1 = 1'b1; addr1 = 10'h003;
      for (int c = 1; c <= 12; c++) begin
         if (c == 2) begin req0 = 1'b1; addr0 = 10'h005; end
         @(negedge clk);
         if (c <= 9) begin
            chk1("d_lock_gnt1", gnt1, c <= 8);
            chk1("d_lock_gnt0", gnt0, c == 9);
         end
         next_cycle();
      end
      clear_inputs();
      $display("scenario lock timeout done");

      // Port 0 locked writes, lock dropped on the third; port 1 read waits.
      do_reset();
      next_cycle(); req0 = 1'b1; we0 = 1'b1; lock0 = 1'b1; addr0 = 10'h008; wdata0 = 32'h1111_1111;
      req1 = 1'b1; addr1 = 10'h008;
      @(negedge clk); chk1("d_drop_gnt0_a", gnt0, 1'b1); chk1("d_drop_gnt1_a", gnt1, 1'b0);
      next_cycle(); wdata0 = 32'h2222_2222;
      @(negedge clk); chk1("d_drop_gnt0_b", gnt0, 1'b1); chk1("d_drop_gnt1_b", gnt1, 1'b0);
      next_cycle(); wdata0 = 32'h3333_3333; lock0 = 1'b0;
      @(negedge clk); chk1("d_drop_gnt0_c", gnt0, 1'b1); chk1("d_drop_gnt1_c", gnt1, 1'b0);
      next_cycle(); req0 = 1'b0; we0 = 1'b0;
      @(negedge clk); chk1("d_drop_gnt1", gnt1, 1'b1);
      next_cycle(); req1 = 1'b0;
      @(negedge clk); chk1("d_drop_rvalid1", rvalid1, 1'b1); chk("d_drop_rdata1", rdata1, 32'h3333_3333);
      $display("scenario lock release done");

      // Reset during ownership with a read outstanding.
      do_reset();
      next_cycle(); req0 = 1'b1; lock0 = 1'b1; addr0 = 10'h004;
      @(negedge clk); chk1("d_rst_gnt0_a", gnt0, 1'b1);
      next_cycle();
      @(negedge clk); chk1("d_rst_gnt0_b", gnt0, 1'b1);
      next_cycle(); rst_n = 1'b0; req1 = 1'b1;
      @(negedge clk);
      chk1("d_rst_rvalid0", rvalid0, 1'b0);
      chk1("d_rst_gnt0", gnt0, 1'b0);
      chk1("d_rst_gnt1", gnt1, 1'b0);
      chk1("d_rst_wen", mem_wen, 1'b0);
      next_cycle();
      @(negedge clk); chk1("d_rst_gnt0_c", gnt0, 1'b0); chk1("d_rst_gnt1_c", gnt1, 1'b0);
      next_cycle(); rst_n = 1'b1; clear_inputs();
      @(negedge clk); chk1("d_rel_rvalid0", rvalid0, 1'b0);
      next_cycle(); req0 = 1'b1; req1 = 1'b1; addr0 = 10'h006; addr1 = 10'h007;
      @(negedge clk); chk1("d_first_gnt0", gnt0, 1'b1); chk1("d_first_gnt1", gnt1, 1'b0);
      next_cycle(); clear_inputs();
      $display("scenario reset mid-lock done");

      // No requests.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         next_cycle();
         @(negedge clk);
         chk1("d_idle_wen", mem_wen, 1'b0);
         chk("d_idle_addr", 32'(mem_addr), 32'd0);
         chk1("d_idle_rvalid0", rvalid0, 1'b0);
         chk1("d_idle_rvalid1", rvalid1, 1'b0);
      end
      $display("scenario idle done");

      // Randomized traffic; requests held until granted.
      do_reset();
      g0_last = 1'b0; g1_last = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         next_cycle();
         rst_n = ($urandom_range(0, 399) != 0);
         if (!req0 || g0_last) begin
            req0 = ($urandom_range(0, 9) < 7); we0 = 1'($urandom_range(0, 1));
            addr0 = 10'($urandom_range(0, 31)); wdata0 = $urandom;
         end
         if (!req1 || g1_last) begin
            req1 = ($urandom_range(0, 9) < 7); we1 = 1'($urandom_range(0, 1));
            addr1 = 10'($urandom_range(0, 31)); wdata1 = $urandom;
         end
         lock0 = ($urandom_range(0, 3) != 0);
         lock1 = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         g0_last = gnt0; g1_last = gnt1;
      end
      next_cycle();
      rst_n = 1'b1;
      clear_inputs();
      @(negedge clk);
      $display("scenario random traffic done");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
